// File: rtl/multi_rate_divider.sv
// Multi-channel programmable rate divider: periodic, one-shot and square-wave ticks per channel.
// Latency: write visible as Active next cycle; first Tick E cycles after the write edge.
// Backpressure: none; write port always ready, one write per cycle.
module multi_rate_divider #(
   parameter int CHANNELS  = 4,
   parameter int DIV_WIDTH = 16,
   localparam int CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                 ClockIn,
   input  logic                 ResetN,
   input  logic                 WrEn,
   input  logic [CHW-1:0]       WrChan,
   input  logic [DIV_WIDTH-1:0] WrDivisor,
   input  logic [1:0]           WrMode,
   input  logic                 SyncRestart,
   output logic [CHANNELS-1:0]  Tick,
   output logic [CHANNELS-1:0]  Wave,
   output logic [CHANNELS-1:0]  Active
);

   typedef enum logic [1:0] {
      MODE_OFF      = 2'b00,
      MODE_PERIODIC = 2'b01,
      MODE_ONESHOT  = 2'b10,
      MODE_SQUARE   = 2'b11
   } mode_t;

   logic [DIV_WIDTH-1:0] divisor_q [CHANNELS];
   logic [DIV_WIDTH-1:0] divisor_d [CHANNELS];
   logic [DIV_WIDTH-1:0] count_q   [CHANNELS];
   logic [DIV_WIDTH-1:0] count_d   [CHANNELS];
   mode_t                mode_q    [CHANNELS];
   mode_t                mode_d    [CHANNELS];
   logic [CHANNELS-1:0]  wave_q;
   logic [CHANNELS-1:0]  wave_d;
   logic [DIV_WIDTH-1:0] wr_reload;

   // Reload value E-1 where E = max(D,1): a zero divisor behaves as divide-by-one.
   function automatic logic [DIV_WIDTH-1:0] reload_of(input logic [DIV_WIDTH-1:0] d);
      return (d == '0) ? '0 : d - DIV_WIDTH'(1);
   endfunction

   assign wr_reload = reload_of(WrDivisor);

   // Next-state per channel: a write wins over restart and expiry; restart wins over counting.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         divisor_d[i] = divisor_q[i];
         count_d[i]   = count_q[i];
         mode_d[i]    = mode_q[i];
         wave_d[i]    = wave_q[i];
         // Out-of-range WrChan values match no channel, so such writes are dropped.
         if (WrEn && (WrChan == CHW'(i))) begin
            divisor_d[i] = WrDivisor;
            mode_d[i]    = mode_t'(WrMode);
            count_d[i]   = wr_reload;
            wave_d[i]    = 1'b0;
         end else if (mode_q[i] != MODE_OFF) begin
            if (SyncRestart) begin
               count_d[i] = reload_of(divisor_q[i]);
               wave_d[i]  = 1'b0;
            end else if (count_q[i] == '0) begin
               case (mode_q[i])
                  MODE_PERIODIC: count_d[i] = reload_of(divisor_q[i]);
                  MODE_SQUARE: begin
                     count_d[i] = reload_of(divisor_q[i]);
                     wave_d[i]  = ~wave_q[i];
                  end
                  MODE_ONESHOT: mode_d[i] = MODE_OFF;
                  default:      mode_d[i] = MODE_OFF;
               endcase
            end else begin
               count_d[i] = count_q[i] - DIV_WIDTH'(1);
            end
         end
      end
   end

   // Channel state registers, cleared asynchronously so all outputs drop at once.
   always_ff @(posedge ClockIn or negedge ResetN) begin
      if (!ResetN) begin
         for (int i = 0; i < CHANNELS; i++) begin
            divisor_q[i] <= '0;
            count_q[i]   <= '0;
            mode_q[i]    <= MODE_OFF;
         end
         wave_q <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            divisor_q[i] <= divisor_d[i];
            count_q[i]   <= count_d[i];
            mode_q[i]    <= mode_d[i];
         end
         wave_q <= wave_d;
      end
   end

   // Outputs decode registered state only; no input reaches an output combinationally.
   always_comb begin
      Tick   = '0;
      Wave   = '0;
      Active = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         Active[i] = (mode_q[i] != MODE_OFF);
         Tick[i]   = (mode_q[i] != MODE_OFF) && (count_q[i] == '0);
         Wave[i]   = (mode_q[i] == MODE_SQUARE) && wave_q[i];
      end
   end

endmodule

// File: tb/tb_multi_rate_divider.sv
// Directed bench for multi_rate_divider with a queue of per-cycle expected outputs.
// Latency: expectations are queued per cycle before stimulus and popped each falling edge.
// Backpressure: not applicable; the write port is always ready.
module tb_multi_rate_divider;

   localparam int CH  = 5;
   localparam int DW  = 16;
   localparam int CHW = 3;

   logic           ClockIn = 1'b0;
   logic           ResetN;
   logic           WrEn;
   logic [CHW-1:0] WrChan;
   logic [DW-1:0]  WrDivisor;
   logic [1:0]     WrMode;
   logic           SyncRestart;
   logic [CH-1:0]  Tick;
   logic [CH-1:0]  Wave;
   logic [CH-1:0]  Active;

   multi_rate_divider #(.CHANNELS(CH), .DIV_WIDTH(DW)) dut (
      .ClockIn     (ClockIn),
      .ResetN      (ResetN),
      .WrEn        (WrEn),
      .WrChan      (WrChan),
      .WrDivisor   (WrDivisor),
      .WrMode      (WrMode),
      .SyncRestart (SyncRestart),
      .Tick        (Tick),
      .Wave        (Wave),
      .Active      (Active)
   );

   always #5 ClockIn = ~ClockIn;

   typedef struct {
      string         tag;
      logic [CH-1:0] tick;
      logic [CH-1:0] wave;
      logic [CH-1:0] active;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   task automatic push_exp(input string tag, input logic [CH-1:0] t,
                           input logic [CH-1:0] w, input logic [CH-1:0] a);
      exp_t e;
      e.tag    = tag;
      e.tick   = t;
      e.wave   = w;
      e.active = a;
      sb.push_back(e);
   endtask

   task automatic check_now();
      exp_t e;
      if (sb.size() == 0) begin
         tests++;
         fails++;
         $error("FAIL scoreboard_underflow: observed empty queue, expected an entry");
         return;
      end
      e = sb.pop_front();
      tests++;
      assert (Tick === e.tick) else begin
         fails++;
         $error("FAIL %s tick: observed %b expected %b", e.tag, Tick, e.tick);
      end
      tests++;
      assert (Wave === e.wave) else begin
         fails++;
         $error("FAIL %s wave: observed %b expected %b", e.tag, Wave, e.wave);
      end
      tests++;
      assert (Active === e.active) else begin
         fails++;
         $error("FAIL %s active: observed %b expected %b", e.tag, Active, e.active);
      end
   endtask

   // Advance n cycles; each falling edge clears one-cycle strobes and checks that cycle.
   task automatic run(input int n);
      repeat (n) begin
         @(negedge ClockIn);
         WrEn        = 1'b0;
         SyncRestart = 1'b0;
         check_now();
      end
   endtask

   task automatic do_write(input int ch, input int d, input logic [1:0] m);
      WrEn      = 1'b1;
      WrChan    = CHW'(ch);
      WrDivisor = DW'(d);
      WrMode    = m;
   endtask

   task automatic do_reset();
      ResetN      = 1'b0;
      WrEn        = 1'b0;
      SyncRestart = 1'b0;
      @(negedge ClockIn);
      ResetN = 1'b1;
   endtask

   initial begin
      logic [CH-1:0] t;
      logic [CH-1:0] w;
      logic [CH-1:0] a;

      ResetN      = 1'b1;
      WrEn        = 1'b0;
      WrChan      = '0;
      WrDivisor   = '0;
      WrMode      = 2'b00;
      SyncRestart = 1'b0;

      // Asynchronous reset with no clock edge yet.
      #1 ResetN = 1'b0;
      #1;
      push_exp("reset", '0, '0, '0);
      check_now();

      // ch0 periodic D=5: ticks in cycles 5, 10, 15.
      do_reset();
      do_write(0, 5, 2'b01);
      for (int c = 1; c <= 16; c++) begin
         t = '0; t[0] = (c % 5 == 0);
         a = '0; a[0] = 1'b1;
         push_exp($sformatf("periodic5_c%0d", c), t, '0, a);
      end
      run(16);

      // ch1 one-shot D=3: single tick in cycle 3, inactive from cycle 4.
      do_reset();
      do_write(1, 3, 2'b10);
      for (int c = 1; c <= 23; c++) begin
         t = '0; t[1] = (c == 3);
         a = '0; a[1] = (c <= 3);
         push_exp($sformatf("oneshot3_c%0d", c), t, '0, a);
      end
      run(23);

      // ch2 square D=4: ticks every 4, wave high 5-8, low 9-12, high 13-16.
      do_reset();
      do_write(2, 4, 2'b11);
      for (int c = 1; c <= 16; c++) begin
         t = '0; t[2] = (c % 4 == 0);
         w = '0; w[2] = (((c - 1) / 4) % 2 == 1);
         a = '0; a[2] = 1'b1;
         push_exp($sformatf("square4_c%0d", c), t, w, a);
      end
      run(16);

      // ch3 D=0 then rewritten D=1: tick every cycle throughout.
      do_reset();
      do_write(3, 0, 2'b01);
      for (int c = 1; c <= 5; c++) push_exp($sformatf("div0_c%0d", c), 5'b01000, '0, 5'b01000);
      run(5);
      do_write(3, 1, 2'b01);
      for (int c = 1; c <= 5; c++) push_exp($sformatf("div1_c%0d", c), 5'b01000, '0, 5'b01000);
      run(5);

      // Out-of-range channel writes change nothing.
      do_write(5, 2, 2'b10);
      for (int c = 1; c <= 5; c++) push_exp($sformatf("badchan5_c%0d", c), 5'b01000, '0, 5'b01000);
      run(5);
      do_write(7, 3, 2'b11);
      for (int c = 1; c <= 3; c++) push_exp($sformatf("badchan7_c%0d", c), 5'b01000, '0, 5'b01000);
      run(3);

      // ch0 D=6; at edge 3 restart together with a write of ch1 D=6: both tick in 9 and 15.
      do_reset();
      do_write(0, 6, 2'b01);
      for (int c = 1; c <= 3; c++) push_exp($sformatf("sync_pre_c%0d", c), '0, '0, 5'b00001);
      run(3);
      do_write(1, 6, 2'b01);
      SyncRestart = 1'b1;
      for (int c = 4; c <= 16; c++) begin
         t = ((c == 9) || (c == 15)) ? 5'b00011 : 5'b00000;
         push_exp($sformatf("sync_c%0d", c), t, '0, 5'b00011);
      end
      run(13);

      // ch0 square D=4 rewritten to square D=3 in its expiry cycle: write wins, no toggle.
      do_reset();
      do_write(0, 4, 2'b11);
      for (int c = 1; c <= 4; c++) begin
         t = '0; t[0] = (c == 4);
         push_exp($sformatf("expiry_pre_c%0d", c), t, '0, 5'b00001);
      end
      run(4);
      do_write(0, 3, 2'b11);
      for (int c = 1; c <= 7; c++) begin
         t = '0; t[0] = (c % 3 == 0);
         w = '0; w[0] = (((c - 1) / 3) % 2 == 1);
         push_exp($sformatf("expiry_post_c%0d", c), t, w, 5'b00001);
      end
      run(7);

      // ch0 D=8; reset dropped mid-cycle 5 clears outputs at once; stays quiet until rewritten.
      do_reset();
      do_write(0, 8, 2'b01);
      for (int c = 1; c <= 4; c++) push_exp($sformatf("arst_pre_c%0d", c), '0, '0, 5'b00001);
      run(4);
      @(posedge ClockIn);
      #2 ResetN = 1'b0;
      #1;
      push_exp("arst_immediate", '0, '0, '0);
      check_now();
      @(negedge ClockIn);
      push_exp("arst_held", '0, '0, '0);
      check_now();
      ResetN = 1'b1;
      for (int c = 1; c <= 20; c++) push_exp($sformatf("arst_quiet_c%0d", c), '0, '0, '0);
      run(20);
      do_write(0, 2, 2'b01);
      for (int c = 1; c <= 4; c++) begin
         t = '0; t[0] = (c % 2 == 0);
         push_exp($sformatf("arst_rewrite_c%0d", c), t, '0, 5'b00001);
      end
      run(4);

      tests++;
      assert (sb.size() === 0) else begin
         fails++;
         $error("FAIL scoreboard_drain: observed %0d leftover entries, expected 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/multi_rate_divider.md
# multi_rate_divider

Multi-channel programmable rate divider: the parametrised successor to the single-channel fixed-speed divider. Each of CHANNELS independent channels holds a DIV_WIDTH-bit divisor and a mode:
- **Periodic:** one-cycle tick every D cycles.
- **One-shot:** a single tick after D cycles, then the channel stops.
- **Square:** periodic tick plus a 50%-duty wave output.

Channels are programmed through a one-cycle write port, and a global restart phase-aligns all running channels. The block feeds enables to display, timer and LED-sequencer logic from the one system clock.

## Interface
- CHANNELS, 4, number of independent channels (≥1)
- DIV_WIDTH, 16, divisor and counter width in bits (≥2)
- ClockIn  in  1  system clock, all state on rising edge
- ResetN  in  1  asynchronous, active-low reset
- WrEn  in  1  write strobe, sampled on ClockIn rising edge
- WrChan  in  max(1,$clog2(CHANNELS))  target channel of write
- WrDivisor  in  DIV_WIDTH  divisor D for written channel
- WrMode  in  2  mode for written channel: 00 off, 01 periodic, 10 one-shot, 11 square
- SyncRestart  in  1  restart all active channels, sampled on rising edge
- Tick  out  CHANNELS  per-channel one-cycle enable pulse
- Wave  out  CHANNELS  per-channel square wave (mode 11 only, else 0)
- Active  out  CHANNELS  per-channel "mode != off"

## Operation
- **Per-channel registers:** Divisor[DIV_WIDTH], Mode[2], Count[DIV_WIDTH], WaveReg.
- **Effective divisor:** E = max(D,1). D=0 behaves exactly as D=1.
- **Write accepted (WrEn=1, WrChan<CHANNELS):**
  - Divisor ← WrDivisor, Mode ← WrMode, Count ← E−1, WaveReg ← 0.
  - A write restarts the channel's phase even if it is already running.
  - WrChan ≥ CHANNELS: write ignored, no state changes.
- **Outputs:**
  - Active[i] = (Mode[i] != 00).
  - Tick[i] = Active[i] && Count[i]==0. Combinational from registers only; no input-to-output path.
- **Active channel, Count != 0:** Count decrements by 1 each edge.
- **Active channel, Count == 0 (expiry edge):**
  - Periodic (01): Count ← E−1.
  - Square (11): Count ← E−1, WaveReg toggles.
  - One-shot (10): Mode ← 00; Count holds 0.
- **Off channel (00):** Count and WaveReg frozen; Tick=0, Wave=0.
- **Wave[i]:** WaveReg[i] when Mode[i]==11, else 0. Period 2E cycles, 50% duty.
- **SyncRestart=1:** every active channel gets Count ← E−1, WaveReg ← 0. Off channels unaffected.
- **Simultaneous WrEn and SyncRestart:** the written channel takes the write values (identical phase result); all other channels restart.
- **Write to channel in its expiry cycle:** the write wins; no reload or toggle from expiry. The Tick in that cycle is still emitted.
- **Counter arithmetic:** unsigned, DIV_WIDTH bits; never wraps, because reload occurs at 0. Maximum period is 2^DIV_WIDTH−1 cycles.

## Timing
- **Reset (ResetN low):** asynchronously clears all registers; Tick, Wave, Active = 0 immediately, with no clock required.
- **Reset release:** takes effect at the next edge. Channels stay off until written.
- **Cycle numbering:** cycle 1 is the cycle after the write edge.
- **Write latency:**
  - Active visible in cycle 1.
  - First Tick in cycle E.
  - Periodic/square ticks then in cycles E, 2E, 3E, ….
  - Wave first rises in cycle E+1.
- **One-shot:** Tick in cycle E only; Active falls in cycle E+1.
- **SyncRestart at edge k:** the next Tick of each active channel is in cycle k+E, counting the cycle after edge k as k+1.
- **Tick width:** exactly one cycle, except E=1, where Tick stays high continuously while active.
- **Write port:** always ready; one write per cycle, no backpressure.

## Test plan
- Reset, write ch0 D=5 mode 01 → Tick[0] high in cycles 5, 10, 15 only; Active[0]=1 from cycle 1.
- Write ch1 D=3 mode 10 → single Tick[1] in cycle 3; Active[1]=0 from cycle 4; no further Tick over 20 cycles.
- Write ch2 D=4 mode 11 → Tick[2] in cycles 4, 8, 12; Wave[2] high cycles 5–8, low 9–12, high 13–16.
- Edge cases:
  - ch3 D=0 mode 01 and D=1 mode 01 → Tick[3] high every cycle.
  - A write with WrChan=5, when CHANNELS=4, changes no output.
- Timed interactions:
  - ch0 D=6 running; at cycle 3 assert SyncRestart with a simultaneous write of ch1 D=6 mode 01 → both tick together in cycles 9 and 15.
  - Rewrite ch0 during its expiry cycle → expiry Tick seen, then new phase from the write.
- ch0 D=8 periodic; drop ResetN asynchronously mid-cycle 5 → Tick, Wave, Active = 0 immediately; after release, no Tick for 20 cycles until ch0 is rewritten.
